// File: rtl/pyc_upsizer_pkg.sv
// Shared helpers for the width upsizer: ceiling log2 and lane-index width derivation.
package pyc_upsizer_pkg;

  function automatic int unsigned pyc_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Lane index is at least one bit wide so RATIO=1 still has a legal counter.
  function automatic int unsigned pyc_idx_w(input int unsigned ratio);
    return (ratio <= 1) ? 1 : pyc_clog2(ratio);
  endfunction

endpackage

// File: rtl/pyc_upsizer.sv
// Ready/valid width upsizer: packs RATIO narrow beats into one wide word, with in_last
// flushing a partial word (marked by out_keep/out_last).
module pyc_upsizer
  import pyc_upsizer_pkg::*;
#(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned RATIO = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IN_W*RATIO-1:0] out_data,
  output logic [RATIO-1:0]      out_keep,
  output logic                  out_last
);

  localparam int unsigned IDX_W = pyc_idx_w(RATIO);
  localparam int unsigned OUT_W = IN_W * RATIO;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic [IDX_W-1:0] r_idx;
  logic [OUT_W-1:0] r_acc;
  logic [RATIO-1:0] r_keep;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic [RATIO-1:0] r_out_keep;
  logic             r_out_last;

  logic             w_accept;
  logic             w_complete;
  logic             w_pop;
  logic [OUT_W-1:0] w_acc_ins;
  logic [RATIO-1:0] w_keep_ins;

  assign in_ready   = !rst && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && ((r_idx == LAST_IDX) || in_last);
  assign w_pop      = r_out_valid && out_ready;

  // Accumulator and keep mask with the current beat dropped into lane r_idx.
  always_comb begin
    w_acc_ins  = r_acc;
    w_keep_ins = r_keep;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_acc_ins[k*IN_W +: IN_W] = in_data;
        w_keep_ins[k]             = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_acc       <= '0;
      r_keep      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_complete) begin
      // A completing beat replaces any word being popped this cycle.
      r_idx       <= '0;
      r_acc       <= '0;
      r_keep      <= '0;
      r_out_valid <= 1'b1;
      r_out_data  <= w_acc_ins;
      r_out_keep  <= w_keep_ins;
      r_out_last  <= in_last;
    end else begin
      if (w_accept) begin
        r_idx  <= r_idx + IDX_W'(1);
        r_acc  <= w_acc_ins;
        r_keep <= w_keep_ins;
      end
      if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_last  = r_out_last;

endmodule
